// File: rtl/home_slot_controller_if.sv
// Frog/house-slot bus between the game core and home_slot_controller.
// The game core drives position/state/events (master); the controller drives the house status (slave).
interface home_slot_controller_if #(
    parameter int NUM_HOUSES       = 3,
    parameter int DATAWIDTH_POS    = 3,
    parameter int DATAWIDTH_ESTADO = 3,
    parameter int DATAWIDTH_BUS    = 8
);
    logic [DATAWIDTH_POS-1:0]    HSC_POSX_IN;
    logic [DATAWIDTH_POS-1:0]    HSC_POSY_IN;
    logic [DATAWIDTH_ESTADO-1:0] HSC_ESTADO_IN;
    logic                        HSC_PERDIO_IN;
    logic                        HSC_GANO_IN;
    logic [DATAWIDTH_BUS-1:0]    HSC_REG7_OUT;
    logic [NUM_HOUSES-1:0]       HSC_MASK_OUT;
    logic [3:0]                  HSC_COUNT_OUT;
    logic                        HSC_ARRIVE_OUT;
    logic                        HSC_BLOCKED_OUT;
    logic                        HSC_ALLHOME_OUT;
    logic [3:0]                  HSC_LEVEL_OUT;

    modport master (
        output HSC_POSX_IN, HSC_POSY_IN, HSC_ESTADO_IN, HSC_PERDIO_IN, HSC_GANO_IN,
        input  HSC_REG7_OUT, HSC_MASK_OUT, HSC_COUNT_OUT, HSC_ARRIVE_OUT,
               HSC_BLOCKED_OUT, HSC_ALLHOME_OUT, HSC_LEVEL_OUT
    );

    modport slave (
        input  HSC_POSX_IN, HSC_POSY_IN, HSC_ESTADO_IN, HSC_PERDIO_IN, HSC_GANO_IN,
        output HSC_REG7_OUT, HSC_MASK_OUT, HSC_COUNT_OUT, HSC_ARRIVE_OUT,
               HSC_BLOCKED_OUT, HSC_ALLHOME_OUT, HSC_LEVEL_OUT
    );
endinterface

// File: rtl/home_slot_controller.sv
// Purpose: tracks frog arrivals in the house row, flags blocked entries and round completion.
// Latency: all outputs registered, one cycle after the sampled inputs.
// Backpressure: none, inputs sampled every cycle. HSC_LEVEL_COUNTER_EN enables the round counter.
module home_slot_controller #(
    parameter int                                  NUM_HOUSES       = 3,
    parameter int                                  DATAWIDTH_POS    = 3,
    parameter int                                  DATAWIDTH_ESTADO = 3,
    parameter int                                  DATAWIDTH_BUS    = 8,
    parameter logic [DATAWIDTH_POS-1:0]            HOUSE_ROW        = 3'b111,
    parameter logic [NUM_HOUSES*DATAWIDTH_POS-1:0] HOUSE_COLS       = {3'b110, 3'b100, 3'b001}
) (
    input logic                   HSC_CLOCK_50,
    input logic                   HSC_RESET,
    home_slot_controller_if.slave hsc
);
    localparam int IDX_W = (NUM_HOUSES > 1) ? $clog2(NUM_HOUSES) : 1;
    localparam logic [DATAWIDTH_ESTADO-1:0] ESTADO_PLAY = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_HOUSES-1:0]    mask_q, mask_d;
    logic [3:0]               count_q, count_d;
    logic [DATAWIDTH_BUS-1:0] reg7_q, reg7_d;
    logic                     arrive_q, arrive_d;
    logic                     blocked_q, blocked_d;
    logic                     allhome_q, allhome_d;

    logic                     playing;
    logic                     row_match;
    logic                     abort;
    logic                     hit_any;
    logic [IDX_W-1:0]         hit_idx;

    assign playing   = (hsc.HSC_ESTADO_IN == ESTADO_PLAY);
    assign row_match = (hsc.HSC_POSY_IN == HOUSE_ROW);
    assign abort     = (hsc.HSC_PERDIO_IN || hsc.HSC_GANO_IN) && (state_q != ST_IDLE);

    // Scan from the top so the lowest index wins when columns are duplicated.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_HOUSES - 1; i >= 0; i--) begin
            if (playing && row_match &&
                (hsc.HSC_POSX_IN == HOUSE_COLS[i*DATAWIDTH_POS +: DATAWIDTH_POS])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        arrive_d  = 1'b0;
        blocked_d = 1'b0;
        allhome_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                if (playing) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit_any) begin
                    if (mask_q[hit_idx]) begin
                        blocked_d = 1'b1;
                    end else begin
                        mask_d[hit_idx] = 1'b1;
                        arrive_d        = 1'b1;
                    end
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!row_match) state_d = (&mask_q) ? ST_CLEAR : ST_PLAY;
            end
            ST_CLEAR: begin
                allhome_d = 1'b1;
                mask_d    = '0;
                state_d   = ST_PLAY;
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
            end
        endcase
        // Lose/win events take priority over anything decided above.
        if (abort) begin
            state_d   = ST_IDLE;
            mask_d    = '0;
            arrive_d  = 1'b0;
            blocked_d = 1'b0;
            allhome_d = 1'b0;
        end
    end

    always_comb begin
        reg7_d  = '0;
        count_d = '0;
        for (int i = 0; i < NUM_HOUSES; i++) begin
            if (mask_d[i]) begin
                reg7_d[HOUSE_COLS[i*DATAWIDTH_POS +: DATAWIDTH_POS]] = 1'b1;
                count_d = count_d + 4'd1;
            end
        end
    end

    always_ff @(posedge HSC_CLOCK_50 or posedge HSC_RESET) begin
        if (HSC_RESET) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            count_q   <= '0;
            reg7_q    <= '0;
            arrive_q  <= 1'b0;
            blocked_q <= 1'b0;
            allhome_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            reg7_q    <= reg7_d;
            arrive_q  <= arrive_d;
            blocked_q <= blocked_d;
            allhome_q <= allhome_d;
        end
    end

    assign hsc.HSC_REG7_OUT    = reg7_q;
    assign hsc.HSC_MASK_OUT    = mask_q;
    assign hsc.HSC_COUNT_OUT   = count_q;
    assign hsc.HSC_ARRIVE_OUT  = arrive_q;
    assign hsc.HSC_BLOCKED_OUT = blocked_q;
    assign hsc.HSC_ALLHOME_OUT = allhome_q;

`ifdef HSC_LEVEL_COUNTER_EN
    logic [3:0] level_q, level_d;
    logic       level_inc;

    // A round only counts when the CLEAR cycle is not overridden by a lose/win event.
    assign level_inc = (state_q == ST_CLEAR) && !abort;

    always_comb begin
        level_d = level_q;
        if (hsc.HSC_PERDIO_IN) begin
            level_d = '0;
        end else if (level_inc && (level_q != 4'hF)) begin
            level_d = level_q + 4'd1;
        end
    end

    always_ff @(posedge HSC_CLOCK_50 or posedge HSC_RESET) begin
        if (HSC_RESET) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign hsc.HSC_LEVEL_OUT = level_q;
`else
    assign hsc.HSC_LEVEL_OUT = 4'd0;
`endif

endmodule
